// File: rtl/cm_dist.sv
// Single-source to N-sink stream distributor: a one-entry stage that locks one enabled consumer per item.
// Optional transfer counter port `cnt` is built when CM_DIST_CNT_EN is defined.

package cm_pkg;
    typedef enum logic [0:0] {
        ARB_MIN = 1'b0,
        ARB_MAX = 1'b1
    } t_arb_algo;
endpackage

module cm_dist #(
    parameter int unsigned       DW   = 32,
    parameter int unsigned       N    = 4,
    parameter cm_pkg::t_arb_algo ALGO = cm_pkg::ARB_MIN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    input  logic [N-1:0]         en,
    output logic [N-1:0]         m_valid,
    input  logic [N-1:0]         m_ready,
    output logic [DW-1:0]        m_data,
    output logic [$clog2(N)-1:0] m_tgt
`ifdef CM_DIST_CNT_EN
    ,
    output logic [31:0]          cnt
`endif
);

    localparam int unsigned TW = $clog2(N);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } t_state;

    t_state         state;
    t_state         state_nxt;
    logic           take_c;
    logic           cap_c;
    logic           found_c;
    logic [TW-1:0]  idx_c;
    logic [TW-1:0]  sel_c;

    // Target selection: scan order depends on ALGO, first enabled consumer wins.
    always_comb begin
        sel_c   = '0;
        found_c = 1'b0;
        idx_c   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (ALGO == cm_pkg::ARB_MIN) begin
                idx_c = TW'(i);
            end else begin
                idx_c = TW'(int'(N) - 1 - i);
            end
            if (!found_c && en[idx_c]) begin
                found_c = 1'b1;
                sel_c   = idx_c;
            end
        end
    end

    assign m_valid = (state == HOLD) ? (N'(1) << m_tgt) : '0;
    assign take_c  = |(m_valid & m_ready);
    assign s_ready = (|en) && ((state == EMPTY) || take_c);
    assign cap_c   = s_valid && s_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (cap_c) state_nxt = HOLD;
            HOLD: begin
                if (cap_c) begin
                    state_nxt = HOLD;
                end else if (take_c) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            m_data <= '0;
            m_tgt  <= '0;
        end else begin
            state <= state_nxt;
            if (cap_c) begin
                m_data <= s_data;
                m_tgt  <= sel_c;
            end
        end
    end

`ifdef CM_DIST_CNT_EN
    // Completed transfers, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (take_c) begin
            cnt <= cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cm_dist.sv
// Bench for cm_dist: ARB_MIN and ARB_MAX instances share stimulus and are checked against an item-level model.
// Also checks the CM_DIST_CNT_EN counter when that macro is defined.

module tb_cm_dist;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [31:0] s_data;
    logic [3:0]  en;
    logic [3:0]  m_ready;

    logic        sr [2];
    logic [3:0]  mv [2];
    logic [31:0] md [2];
    logic [1:0]  mt [2];
`ifdef CM_DIST_CNT_EN
    logic [31:0] cn [2];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one optional held item per instance.
    bit          h_hold [2];
    logic [31:0] h_data [2];
    int          h_tgt  [2];
    logic [31:0] h_cnt  [2];

    always #5 clk = ~clk;

    cm_dist #(.DW(32), .N(4), .ALGO(cm_pkg::ARB_MIN)) u_min (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr[0]), .s_data(s_data),
        .en(en), .m_valid(mv[0]), .m_ready(m_ready), .m_data(md[0]), .m_tgt(mt[0])
`ifdef CM_DIST_CNT_EN
        , .cnt(cn[0])
`endif
    );

    cm_dist #(.DW(32), .N(4), .ALGO(cm_pkg::ARB_MAX)) u_max (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr[1]), .s_data(s_data),
        .en(en), .m_valid(mv[1]), .m_ready(m_ready), .m_data(md[1]), .m_tgt(mt[1])
`ifdef CM_DIST_CNT_EN
        , .cnt(cn[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // k=0 picks the lowest enabled consumer, k=1 the highest.
    function automatic int pick(input int k, input logic [3:0] e);
        if (k == 0) begin
            for (int i = 0; i < 4; i++) if (e[i]) return i;
        end else begin
            for (int i = 3; i >= 0; i--) if (e[i]) return i;
        end
        return 0;
    endfunction

    function automatic bit exp_ready(input int k);
        return (en != 4'b0) && (!h_hold[k] || m_ready[h_tgt[k]]);
    endfunction

    // Move to mid-cycle and compare every output of both instances with the model.
    task automatic settle();
        logic [3:0] ev;
        #4;
        for (int k = 0; k < 2; k++) begin
            ev = h_hold[k] ? (4'b0001 << h_tgt[k]) : 4'b0000;
            chk($sformatf("m_valid[%0d]", k), 32'(mv[k]), 32'(ev));
            chk($sformatf("s_ready[%0d]", k), 32'(sr[k]), 32'(exp_ready(k)));
            chk($sformatf("m_data[%0d]", k), md[k], h_data[k]);
            chk($sformatf("m_tgt[%0d]", k), 32'(mt[k]), 32'(h_tgt[k]));
`ifdef CM_DIST_CNT_EN
            chk($sformatf("cnt[%0d]", k), cn[k], h_cnt[k]);
`endif
        end
    endtask

    // Advance one clock and apply the item-level transfer rules to the model.
    task automatic tick();
        bit take;
        bit cap;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                h_hold[k] = 1'b0;
                h_data[k] = '0;
                h_tgt[k]  = 0;
                h_cnt[k]  = '0;
            end else begin
                take = h_hold[k] && m_ready[h_tgt[k]];
                cap  = s_valid && exp_ready(k);
                if (take) h_cnt[k] = h_cnt[k] + 32'd1;
                if (cap) begin
                    h_hold[k] = 1'b1;
                    h_data[k] = s_data;
                    h_tgt[k]  = pick(k, en);
                end else if (take) begin
                    h_hold[k] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; en = 4'b1111; m_ready = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            h_hold[k] = 1'b0; h_data[k] = '0; h_tgt[k] = 0; h_cnt[k] = '0;
        end
        tick();

        // Reset values and idle
        settle();
        chk("rst_s_ready", 32'(sr[0]), 32'd1);
        chk("rst_m_valid", 32'(mv[0]), 32'd0);
        chk("rst_m_tgt", 32'(mt[0]), 32'd0);
        tick();
        rst = 1'b0;
        cyc();

        // Single item, lowest enabled consumer, taken immediately
        en = 4'b0110; m_ready = 4'b1111; s_valid = 1'b1; s_data = 32'hA5A5_0001;
        cyc();
        s_valid = 1'b0;
        settle();
        chk("min_m_valid", 32'(mv[0]), 32'h2);
        chk("min_m_data", md[0], 32'hA5A5_0001);
        chk("max_m_valid", 32'(mv[1]), 32'h4);
        tick();
        settle();
        chk("min_drained", 32'(mv[0]), 32'h0);
        tick();

        // Back-to-back stream into consumer 2
        do_reset();
        en = 4'b0110; m_ready = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 32'h1000 + 32'(i);
            settle();
            chk("stream_s_ready", 32'(sr[1]), 32'd1);
            tick();
        end
        s_valid = 1'b0;
        cyc();
        settle();
        chk("stream_idle", 32'(mv[1]), 32'h0);
`ifdef CM_DIST_CNT_EN
        chk("stream_cnt", cn[1], 32'd8);
`endif
        tick();

        // Lock: target 1 stalls while en moves elsewhere
        do_reset();
        en = 4'b0110; m_ready = 4'b0000; s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        cyc();
        en = 4'b1000; s_data = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("lock_m_valid", 32'(mv[0]), 32'h2);
            chk("lock_m_tgt", 32'(mt[0]), 32'd1);
            chk("lock_m_data", md[0], 32'hDEAD_BEEF);
            chk("lock_s_ready", 32'(sr[0]), 32'd0);
            tick();
        end
        s_valid = 1'b0; m_ready = 4'b0010;
        cyc();
        settle();
        chk("lock_done", 32'(mv[0]), 32'h0);
        tick();
        m_ready = 4'b1111;
        cyc();

        // No enabled consumer blocks capture
        do_reset();
        en = 4'b0000; s_valid = 1'b1; s_data = 32'h5555_0000;
        settle();
        chk("en0_s_ready", 32'(sr[0]), 32'd0);
        tick();
        settle();
        chk("en0_m_valid", 32'(mv[0]), 32'h0);
        en = 4'b0001; s_data = 32'h5555_0001;
        settle();
        chk("en1_s_ready", 32'(sr[0]), 32'd1);
        tick();
        s_valid = 1'b0;
        settle();
        chk("en1_m_valid", 32'(mv[0]), 32'h1);
        chk("en1_m_tgt", 32'(mt[0]), 32'd0);
        tick();

        // Reset while holding discards the item
        do_reset();
        en = 4'b1111; m_ready = 4'b0000; s_valid = 1'b1; s_data = 32'h7777_7777;
        cyc();
        rst = 1'b1; s_valid = 1'b0; m_ready = 4'b1111;
        tick();
        rst = 1'b0;
        settle();
        chk("rsthold_m_valid", 32'(mv[0]), 32'h0);
`ifdef CM_DIST_CNT_EN
        chk("rsthold_cnt", cn[0], 32'd0);
`endif
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = $urandom;
            en      = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            m_ready = 4'($urandom);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
